// File: rtl/snoop_bus_arbiter.sv
// Snoop bus transmit arbiter.
// Each requester owns a small FIFO of coherence messages ({prefix, addr}).
// Every cycle one non-empty FIFO is picked round-robin and its head word is
// registered onto the shared bus. When nothing is pending, the bus carries
// the defined idle word and bus_valid is low.
module snoop_bus_arbiter #(
    parameter int N_REQ = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int PREFIX_WIDTH = 2,
    parameter logic [PREFIX_WIDTH-1:0] IDLE_PREFIX = '0
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic [N_REQ-1:0]                              req_valid,
    input  logic [N_REQ*PREFIX_WIDTH-1:0]                 req_prefix,
    input  logic [N_REQ*ADDR_WIDTH-1:0]                   req_addr,
    output logic [N_REQ-1:0]                              req_ready,
    output logic [PREFIX_WIDTH+ADDR_WIDTH-1:0]            bus,
    output logic                                          bus_valid,
    output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0]  bus_src
);

    localparam int SRC_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int PTR_W  = IDX_W + 1;
    localparam int WORD_W = PREFIX_WIDTH + ADDR_WIDTH;

    typedef logic [PREFIX_WIDTH-1:0] bus_prefix_t;

    localparam bus_prefix_t       IDLE_P    = IDLE_PREFIX;
    localparam logic [WORD_W-1:0] IDLE_WORD = {IDLE_P, {ADDR_WIDTH{1'b0}}};

    // Message storage and per-requester pointers. Pointers carry one extra
    // wrap bit so that full and empty can be told apart.
    logic [WORD_W-1:0] fifo_mem [N_REQ][DEPTH];
    logic [PTR_W-1:0]  wr_ptr [N_REQ];
    logic [PTR_W-1:0]  rd_ptr [N_REQ];

    logic [N_REQ-1:0]  fifo_empty;
    logic [N_REQ-1:0]  fifo_full;
    logic [N_REQ-1:0]  push;
    logic [N_REQ-1:0]  pop;

    logic [SRC_W-1:0]  rr_ptr;
    logic [SRC_W-1:0]  grant_idx;
    logic [SRC_W-1:0]  rr_next;
    logic [SRC_W-1:0]  cand;
    logic              grant_valid;

    // FIFO status: empty when pointers match, full when only the wrap bit differs.
    always_comb begin
        fifo_empty = '0;
        fifo_full  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            fifo_empty[i] = (wr_ptr[i] == rd_ptr[i]);
            fifo_full[i]  = (wr_ptr[i][PTR_W-1] != rd_ptr[i][PTR_W-1]) &&
                            (wr_ptr[i][IDX_W-1:0] == rd_ptr[i][IDX_W-1:0]);
        end
    end

    // Ready depends only on fullness; a same-cycle pop never frees a slot early.
    assign req_ready = ~fifo_full;
    assign push      = req_valid & ~fifo_full;

    // Round-robin pick of the first non-empty FIFO starting at rr_ptr.
    // Only entries already stored count, so a word pushed this cycle waits.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = rr_ptr;
        cand        = '0;
        pop         = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = SRC_W'((int'(rr_ptr) + k) % N_REQ);
            if (!grant_valid && !fifo_empty[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
        if (grant_valid) begin
            pop[grant_idx] = 1'b1;
        end
        rr_next = (grant_idx == SRC_W'(N_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clock) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (push[i] && !reset) begin
                fifo_mem[i][wr_ptr[i][IDX_W-1:0]] <=
                    {req_prefix[i*PREFIX_WIDTH +: PREFIX_WIDTH],
                     req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]};
            end
        end
    end

    // Pointer, round-robin and registered bus update; reset drops all queued work.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_REQ; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
            rr_ptr    <= '0;
            bus       <= IDLE_WORD;
            bus_valid <= 1'b0;
            bus_src   <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                end
            end
            if (grant_valid) begin
                bus       <= fifo_mem[grant_idx][rd_ptr[grant_idx][IDX_W-1:0]];
                bus_valid <= 1'b1;
                bus_src   <= grant_idx;
                rr_ptr    <= rr_next;
            end else begin
                bus       <= IDLE_WORD;
                bus_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Testbench for snoop_bus_arbiter: directed scenarios plus random traffic,
// compared against a queue-based model of the arbitration rules.
module tb_snoop_bus_arbiter;

    localparam int N_REQ = 2;
    localparam int ADDR_WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int PREFIX_WIDTH = 2;
    localparam logic [1:0] IDLE_PREFIX = 2'd0;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [3:0]  req_prefix;
    logic [15:0] req_addr;
    logic [1:0]  req_ready;
    logic [9:0]  bus;
    logic        bus_valid;
    logic [0:0]  bus_src;

    // Free-running clock, 10 time units per period.
    always #5 clock = ~clock;

    snoop_bus_arbiter #(
        .N_REQ(N_REQ),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH(DEPTH),
        .PREFIX_WIDTH(PREFIX_WIDTH),
        .IDLE_PREFIX(IDLE_PREFIX)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req_valid(req_valid),
        .req_prefix(req_prefix),
        .req_addr(req_addr),
        .req_ready(req_ready),
        .bus(bus),
        .bus_valid(bus_valid),
        .bus_src(bus_src)
    );

    int tests_run = 0;
    int tests_failed = 0;

    logic [9:0] q0[$];
    logic [9:0] q1[$];
    int         rr_model = 0;
    logic [9:0] exp_bus = 10'h000;
    logic       exp_valid = 1'b0;
    int         exp_src = 0;
    logic [1:0] last_acc = 2'b00;

    int         left[2];
    logic [7:0] next_addr[2];

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    // Reference: one clock edge of the arbiter expressed as queue operations.
    task automatic modelEdge(input logic rst, input logic [1:0] valid,
                             input logic [9:0] w0, input logic [9:0] w1);
        int winner;
        int c;
        logic [1:0] acc;
        acc = 2'b00;
        if (rst) begin
            q0.delete();
            q1.delete();
            rr_model  = 0;
            exp_bus   = 10'h000;
            exp_valid = 1'b0;
            exp_src   = 0;
        end else begin
            acc[0] = valid[0] && (q0.size() < DEPTH);
            acc[1] = valid[1] && (q1.size() < DEPTH);
            winner = -1;
            for (int k = 0; k < N_REQ; k++) begin
                c = (rr_model + k) % N_REQ;
                if (winner < 0 && qsize(c) > 0) winner = c;
            end
            if (winner == 0) exp_bus = q0.pop_front();
            else if (winner == 1) exp_bus = q1.pop_front();
            if (winner >= 0) begin
                exp_valid = 1'b1;
                exp_src   = winner;
                rr_model  = (winner + 1) % N_REQ;
            end else begin
                exp_bus   = {IDLE_PREFIX, 8'h00};
                exp_valid = 1'b0;
            end
            if (acc[0]) q0.push_back(w0);
            if (acc[1]) q1.push_back(w1);
        end
        last_acc = acc;
    endtask

    // Drive one cycle of inputs (called at negedge), advance the model at the
    // edge and compare registered outputs at the following negedge.
    task automatic applyStimulus(input logic rst, input logic [1:0] valid,
                                 input logic [9:0] w0, input logic [9:0] w1);
        reset      = rst;
        req_valid  = valid;
        req_prefix = {w1[9:8], w0[9:8]};
        req_addr   = {w1[7:0], w0[7:0]};
        #1;
        checkOutput("req_ready", req_ready,
                    {(q1.size() < DEPTH), (q0.size() < DEPTH)});
        @(posedge clock);
        modelEdge(rst, valid, w0, w1);
        @(negedge clock);
        checkOutput("bus", bus, exp_bus);
        checkOutput("bus_valid", bus_valid, exp_valid);
        checkOutput("bus_src", bus_src, exp_src);
    endtask

    // Stream sequential addresses per requester; an offer is held until taken.
    task automatic runStream(input int cycles, input bit rand_mode);
        logic [9:0] w[2];
        logic [1:0] v;
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < 2; i++) begin
                v[i] = (left[i] > 0) && (!rand_mode || $urandom_range(0, 1) == 1);
                w[i] = {rand_mode ? 2'($urandom_range(0, 3)) : 2'(i + 1), next_addr[i]};
            end
            applyStimulus(1'b0, v, w[0], w[1]);
            for (int i = 0; i < 2; i++) begin
                if (last_acc[i]) begin
                    next_addr[i]++;
                    left[i]--;
                end
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 2'b00;
        req_prefix = '0;
        req_addr   = '0;
        left[0] = 0; left[1] = 0;
        next_addr[0] = 8'h00; next_addr[1] = 8'h00;

        // Reset held for two edges.
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("rst_bus", bus, 10'h000);
        checkOutput("rst_valid", bus_valid, 1'b0);
        checkOutput("rst_ready", req_ready, 2'b11);
        checkOutput("rst_src", bus_src, 1'b0);

        // Single message with one-cycle latency, then idle.
        applyStimulus(1'b0, 2'b01, {2'd1, 8'h3C}, 10'h000);
        checkOutput("single_not_yet", bus_valid, 1'b0);
        applyStimulus(1'b0, 2'b00, 10'h000, 10'h000);
        checkOutput("single_bus", bus, 10'h13C);
        checkOutput("single_src", bus_src, 1'b0);
        applyStimulus(1'b0, 2'b00, 10'h000, 10'h000);
        checkOutput("single_idle", bus_valid, 1'b0);

        // Contention with rr=1, then with rr=0. Prefix 0 still issues.
        applyStimulus(1'b0, 2'b11, 10'h010, 10'h320);
        applyStimulus(1'b0, 2'b00, 10'h000, 10'h000);
        checkOutput("cont1_first", {bus_src, bus}, {1'b1, 10'h320});
        applyStimulus(1'b0, 2'b00, 10'h000, 10'h000);
        checkOutput("cont1_second", {bus_src, bus}, {1'b0, 10'h010});
        applyStimulus(1'b0, 2'b10, 10'h000, 10'h321);
        applyStimulus(1'b0, 2'b00, 10'h000, 10'h000);
        checkOutput("cont_setup", {bus_src, bus}, {1'b1, 10'h321});
        applyStimulus(1'b0, 2'b11, 10'h011, 10'h322);
        applyStimulus(1'b0, 2'b00, 10'h000, 10'h000);
        checkOutput("cont0_first", {bus_src, bus}, {1'b0, 10'h011});
        applyStimulus(1'b0, 2'b00, 10'h000, 10'h000);
        checkOutput("cont0_second", {bus_src, bus}, {1'b1, 10'h322});

        // Fill req0 while req1 streams continuously; offers stall when full.
        left[0] = 8; next_addr[0] = 8'h01;
        left[1] = 16; next_addr[1] = 8'h80;
        runStream(20, 1'b0);
        left[0] = 0; left[1] = 0;
        runStream(12, 1'b0);

        // Ten messages through req1 to exercise pointer wrap.
        left[1] = 10; next_addr[1] = 8'h00;
        runStream(24, 1'b0);

        // Reset after the first of three queued messages has issued.
        left[0] = 3; next_addr[0] = 8'h50;
        runStream(2, 1'b0);
        checkOutput("midrst_first", {bus_valid, bus}, {1'b1, 10'h150});
        applyStimulus(1'b1, 2'b01, {2'd1, next_addr[0]}, 10'h000);
        checkOutput("midrst_after", bus_valid, 1'b0);
        left[0] = 0;
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, 2'b00, 10'h000, 10'h000);
            checkOutput("midrst_quiet", bus_valid, 1'b0);
        end

        // Random traffic with random prefixes.
        left[0] = 400; left[1] = 400;
        runStream(400, 1'b1);
        left[0] = 0; left[1] = 0;
        runStream(12, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
